pipe_hazard_ctrl: RTL

Central stall/flush and trap sequencer for the 3-stage (Fetch / Execute / Memory-Writeback) RV32I pipeline. It drives the hold, bubble and CSR-flush controls of the Fetch/Execute and Execute/Memory-Writeback pipeline registers and the PC source select. It also runs the interrupt-entry and mret-return sequence, so that trap redirects, branch flushes and load-use stalls never collide.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/trap sequencer:
// sequencer states, PC source encodings and the bubble instruction.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_DRAIN = 2'd1,
        TRAP_ENTER = 2'd2,
        HOLDOFF    = 2'd3
    } pipe_state_t;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_MTVEC  = 2'b10;
    localparam logic [1:0] PC_MEPC   = 2'b11;

    // addi x0, x0, 0 -- loaded into Fetch/Execute on a bubble
    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in Memory-Writeback writes a register
// that the Execute instruction actually reads. Writes to x0 never hazard.
module hazard_detect #(
    parameter int NUM_REGS = 32
) (
    input  logic                        load_MW,
    input  logic [$clog2(NUM_REGS)-1:0] rd_MW,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_E,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_E,
    input  logic                        rs1_used_E,
    input  logic                        rs2_used_E,
    output logic                        load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used_E && (rs1_E == rd_MW);
    assign rs2_hit  = rs2_used_E && (rs2_E == rd_MW);
    assign load_use = load_MW && (rd_MW != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush and trap sequencer for the 3-stage RV32I pipeline.
// Build option PIPE_IRQ_EN enables interrupt entry (TRAP_DRAIN/TRAP_ENTER);
// without it irq_pending is ignored and only mret/HOLDOFF remain.
// Outputs are combinational from the registered state and current inputs,
// and are forced low while rst is asserted.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_busy,
    input  logic                        br_taken,
    input  logic                        load_MW,
    input  logic [$clog2(NUM_REGS)-1:0] rd_MW,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_E,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_E,
    input  logic                        rs1_used_E,
    input  logic                        rs2_used_E,
    input  logic                        is_mretE,
    input  logic                        irq_pending,
    output logic                        Stall,
    output logic                        Flush,
    output logic                        csr_Flush,
    output logic                        FlushM,
    output logic                        StallM,
    output logic [1:0]                  pc_sel,
    output logic                        epc_we,
    output logic                        epc_src,
    output logic                        mret_ack,
    output logic                        trap_busy,
    output logic [31:0]                 bubble_inst,
    output logic [1:0]                  dbg_state
);

    pipe_state_t state;
    pipe_state_t state_nxt;
    logic        load_use;

`ifndef PIPE_IRQ_EN
    logic unused_irq;
    assign unused_irq = irq_pending;
`endif

    hazard_detect #(
        .NUM_REGS(NUM_REGS)
    ) u_hazard_detect (
        .load_MW   (load_MW),
        .rd_MW     (rd_MW),
        .rs1_E     (rs1_E),
        .rs2_E     (rs2_E),
        .rs1_used_E(rs1_used_E),
        .rs2_used_E(rs2_used_E),
        .load_use  (load_use)
    );

    assign bubble_inst = NOP_INST;
    assign dbg_state   = state;

    // Sequencer state register; reset aborts any trap in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pipeline controls. Priority in RUN:
    // mem_busy > mret > irq > branch > load-use.
    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        Flush     = 1'b0;
        csr_Flush = 1'b0;
        FlushM    = 1'b0;
        StallM    = 1'b0;
        pc_sel    = PC_PLUS4;
        epc_we    = 1'b0;
        epc_src   = 1'b0;
        mret_ack  = 1'b0;
        trap_busy = (state != RUN);

        if (mem_busy) begin
            // Freeze the whole pipe; an interrupt can still be latched
            // so the trap is taken as soon as memory is ready.
            Stall  = 1'b1;
            StallM = 1'b1;
`ifdef PIPE_IRQ_EN
            if (state == RUN && irq_pending) begin
                state_nxt = TRAP_DRAIN;
            end
`endif
        end else begin
            case (state)
                RUN: begin
                    if (is_mretE) begin
                        pc_sel    = PC_MEPC;
                        csr_Flush = 1'b1;
                        mret_ack  = 1'b1;
                        state_nxt = HOLDOFF;
`ifdef PIPE_IRQ_EN
                    end else if (irq_pending) begin
                        // Let the Execute instruction complete this cycle.
                        state_nxt = TRAP_ENTER;
`endif
                    end else if (br_taken) begin
                        pc_sel = PC_BRANCH;
                        Flush  = 1'b1;
                    end else if (load_use) begin
                        Stall  = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                HOLDOFF: begin
                    // irq ignored for one cycle while MIE settles.
                    if (br_taken) begin
                        pc_sel = PC_BRANCH;
                        Flush  = 1'b1;
                    end else if (load_use) begin
                        Stall  = 1'b1;
                        FlushM = 1'b1;
                    end
                    state_nxt = RUN;
                end
`ifdef PIPE_IRQ_EN
                TRAP_DRAIN: begin
                    state_nxt = TRAP_ENTER;
                end
                TRAP_ENTER: begin
                    epc_we    = 1'b1;
                    epc_src   = br_taken;
                    pc_sel    = PC_MTVEC;
                    Flush     = 1'b1;
                    csr_Flush = 1'b1;
                    FlushM    = 1'b1;
                    state_nxt = HOLDOFF;
                end
`endif
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end

        if (!rst) begin
            Stall     = 1'b0;
            Flush     = 1'b0;
            csr_Flush = 1'b0;
            FlushM    = 1'b0;
            StallM    = 1'b0;
            pc_sel    = PC_PLUS4;
            epc_we    = 1'b0;
            epc_src   = 1'b0;
            mret_ack  = 1'b0;
            trap_busy = 1'b0;
        end
    end

endmodule
